// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arbitrates a capture RAM between the acquisition
// block and the readout block. In oscilloscope mode it captures at once. In
// logic-analyser mode it waits for an ADC threshold crossing, or a timeout,
// before capturing.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   start      host request, only honoured in IDLE
//   abort      host cancel, honoured in every state
//   mode       0 = immediate capture, 1 = triggered capture
//   trig_edge  1 = rising crossing, 0 = falling crossing
//   threshold  unsigned trigger level
//   adc_data   unsigned ADC sample, one per clk
//   done_acq   RAM full (level)
//   done_rd    RAM drained (level)
//   grant_acq  acquisition block owns the RAM write port
//   grant_rd   readout block owns the RAM read port
//   busy       sequencer not idle
//   trig_to    sticky: last capture was started by timeout
//   seq_done   one-cycle pulse when a full sequence completes
module acq_sequencer #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mode,
  input  logic       trig_edge,
  input  logic [7:0] threshold,
  input  logic [7:0] adc_data,
  input  logic       done_acq,
  input  logic       done_rd,
  output logic       grant_acq,
  output logic       grant_rd,
  output logic       busy,
  output logic       trig_to,
  output logic       seq_done
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_ACQ  = 2'd2,
    S_READ = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             above_q;
  logic             above_qq;
  // above_q / above_qq hold samples taken while in ARM
  logic             above_vld_q;
  logic             above_vld_qq;

  logic above_c;
  logic trig_evt_c;
  logic tmo_c;

  // Threshold comparison and edge/timeout detection in ARM
  always_comb begin
    above_c    = (adc_data >= threshold);
    trig_evt_c = 1'b0;
    if ((state_q == S_ARM) && above_vld_q && above_vld_qq) begin
      trig_evt_c = trig_edge ? (above_q && !above_qq) : (!above_q && above_qq);
    end
    tmo_c = (state_q == S_ARM) && (cnt_q == CNT_LAST);
  end

  // Sequencer FSM with registered Moore outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      above_q      <= 1'b0;
      above_qq     <= 1'b0;
      above_vld_q  <= 1'b0;
      above_vld_qq <= 1'b0;
      grant_acq    <= 1'b0;
      grant_rd     <= 1'b0;
      busy         <= 1'b0;
      trig_to      <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      above_q      <= above_c;
      above_qq     <= above_q;
      above_vld_q  <= (state_q == S_ARM);
      above_vld_qq <= above_vld_q && (state_q == S_ARM);
      seq_done     <= 1'b0;

      if (abort) begin
        state_q   <= S_IDLE;
        grant_acq <= 1'b0;
        grant_rd  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              trig_to <= 1'b0;
              busy    <= 1'b1;
              if (mode) begin
                state_q <= S_ARM;
                cnt_q   <= '0;
              end else begin
                state_q   <= S_ACQ;
                grant_acq <= 1'b1;
              end
            end
          end
          S_ARM: begin
            // An edge in the same cycle as the timeout wins, leaving trig_to low
            if (trig_evt_c) begin
              state_q   <= S_ACQ;
              grant_acq <= 1'b1;
            end else if (tmo_c) begin
              state_q   <= S_ACQ;
              grant_acq <= 1'b1;
              trig_to   <= 1'b1;
            end else if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_ACQ: begin
            if (done_acq) begin
              state_q   <= S_READ;
              grant_acq <= 1'b0;
              grant_rd  <= 1'b1;
            end
          end
          S_READ: begin
            if (done_rd) begin
              state_q  <= S_IDLE;
              grant_rd <= 1'b0;
              busy     <= 1'b0;
              seq_done <= 1'b1;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            grant_acq <= 1'b0;
            grant_rd  <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
